ssm_tile_sched: RTL and testbench
=================================

# ssm_tile_sched

Tile scheduler for the FP16 SSM tile engine. It walks the (head-tile, P-tile) grid of one SSM step in head-major order: it pulses the engine start, waits for engine done with a watchdog, and presents each finished tile's coordinates on a valid/ready writeback port for the y-scatter logic. It sits between the step-level control (start/abort) and one `ssm_block_fp16_top` instance plus its slicing/scatter muxes.

## Interface
- `H`, 24, total heads
- `P`, 64, head dimension
- `H_TILE`, 12, heads per tile; H must be a multiple of H_TILE
- `P_TILE`, 16, P elements per tile; P must be a multiple of P_TILE
- `IW`, 4, width of tile index outputs
- `TIMEOUT`, 4096, max WAIT cycles per tile before abort-with-error (≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a step; accepted only in IDLE
- `abort`  in  1  cancel the run; priority over everything except rst
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse in FINISH
- `err_timeout`  out  1  sticky; set on watchdog expiry, cleared on accepted start or rst
- `tile_start`  out  1  one-cycle pulse to the engine, high only in LAUNCH
- `tile_done`  in  1  engine completion; sampled only in WAIT
- `tile_h_idx`  out  IW  current head-tile index, 0..H/H_TILE-1
- `tile_p_idx`  out  IW  current P-tile index, 0..P/P_TILE-1
- `wb_valid`  out  1  finished-tile writeback request, high only in WRITE
- `wb_ready`  in  1  scatter logic accepts writeback
- `tile_count`  out  8  tiles written back in the current/last run

## Operation
- States: IDLE, LAUNCH, WAIT, WRITE, FINISH. NT = (H/H_TILE)*(P/P_TILE).
- IDLE: if `start` and not `abort`, clear indices, `tile_count`, `err_timeout`; go to LAUNCH.
- LAUNCH (1 cycle): `tile_start`=1; clear the wait counter; go to WAIT.
- WAIT: if `tile_done`, go to WRITE. Otherwise increment the wait counter. If the counter equals TIMEOUT-1 with `tile_done` low, set `err_timeout` and go to FINISH.
- WRITE: `wb_valid`=1 with the indices held stable. On `wb_valid&&wb_ready`, increment `tile_count`.
  - If this was the last tile (h=H/H_TILE-1, p=P/P_TILE-1), go to FINISH.
  - Else if p is at its last value, p←0 and h←h+1; otherwise p←p+1. Then go to LAUNCH.
- FINISH (1 cycle): `done`=1; go to IDLE. Indices and `tile_count` hold their values until the next accepted start.
- `abort` in any non-IDLE state: go to IDLE next cycle. No `done`, no `err_timeout` change, counts held. `abort` in IDLE blocks `start`.
- `start` while busy is ignored. `tile_done` outside WAIT is ignored. `tile_done` and timeout in the same cycle: done wins.
- Index arithmetic is unsigned with no wrap beyond grid bounds. `tile_count` saturates at 255.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err_timeout`, `tile_start`, `wb_valid` = 0; indices 0; `tile_count` 0. `rst` mid-run returns to IDLE on the next edge, with no `done` pulse.
- All outputs are registered or decoded from the registered state; no input-to-output combinational path.
- Cycle timing (`start` sampled at cycle 0):
  - LAUNCH at cycle 1.
  - If the engine raises `tile_done` L cycles after `tile_start` (L≥1) and `wb_ready` is held high, the tile period is L+2 cycles.
  - `done` pulses at cycle 1+NT*(L+2); `busy` is high from cycle 1 through that cycle.
- Each cycle of `wb_ready` low in WRITE adds exactly one cycle.
- Timeout: WAIT entered at cycle w, `tile_done` held low → FINISH at cycle w+TIMEOUT.

## Test plan
- Nominal run, defaults, L=10, `wb_ready`=1: the (h,p) sequence observed at `wb_valid` is (0,0),(0,1),(0,2),(0,3),(1,0)…(1,3); `done` pulses at cycle 97; `tile_count`=8; `err_timeout`=0.
- Backpressure: `wb_ready` low for 3 cycles on tile 2 only, L=10 → `done` at cycle 100; indices stable while `wb_valid` is high.
- Timeout with TIMEOUT=16: the engine never responds on tile 3 → `err_timeout`=1 and `done` 16 cycles after that tile's WAIT entry; `tile_count`=3. A subsequent `start` clears `err_timeout`.
- Abort in WAIT of tile 5 → IDLE next cycle, `busy`=0, no `done`, `tile_count`=5; a following `start` restarts at (0,0).
- `start` pulsed during WAIT and a stray `tile_done` pulsed during WRITE → both ignored; sequence and timing identical to the nominal run.
- `rst` asserted in WRITE of tile 4 → next cycle all outputs at reset values; `start` with `abort` in the same cycle in IDLE → stays IDLE.

Source files
------------

// File: rtl/ssm_tile_sched.sv
// Tile scheduler for the FP16 SSM tile engine: walks the head-tile x P-tile grid
// head-major, launching the engine per tile and handing finished tiles to writeback.
module ssm_tile_sched #(
    parameter int H       = 24,
    parameter int P       = 64,
    parameter int H_TILE  = 12,
    parameter int P_TILE  = 16,
    parameter int IW      = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          tile_start,
    input  logic          tile_done,
    output logic [IW-1:0] tile_h_idx,
    output logic [IW-1:0] tile_p_idx,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [7:0]    tile_count
);
    localparam int NH = H / H_TILE;
    localparam int NP = P / P_TILE;
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WMAX   = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] H_LAST = IW'(NH - 1);
    localparam logic [IW-1:0] P_LAST = IW'(NP - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WRITE, FINISH} state_t;

    state_t        state;
    logic [WW-1:0] wcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            err_timeout <= 1'b0;
            tile_h_idx  <= '0;
            tile_p_idx  <= '0;
            tile_count  <= '0;
        end else if (abort && state != IDLE) begin
            // Cancel leaves indices, count and error flag as they were.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        tile_h_idx  <= '0;
                        tile_p_idx  <= '0;
                        tile_count  <= '0;
                        err_timeout <= 1'b0;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion takes precedence over a watchdog expiry in the same cycle.
                    if (tile_done) begin
                        state <= WRITE;
                    end else if (wcnt == WMAX) begin
                        err_timeout <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (wb_ready) begin
                        if (tile_count != 8'hFF)
                            tile_count <= tile_count + 8'd1;
                        if (tile_h_idx == H_LAST && tile_p_idx == P_LAST) begin
                            state <= FINISH;
                        end else begin
                            if (tile_p_idx == P_LAST) begin
                                tile_p_idx <= '0;
                                tile_h_idx <= tile_h_idx + 1'b1;
                            end else begin
                                tile_p_idx <= tile_p_idx + 1'b1;
                            end
                            state <= LAUNCH;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign tile_start = (state == LAUNCH);
    assign wb_valid   = (state == WRITE);

endmodule

// File: tb/tb_ssm_tile_sched.sv
// Directed bench for ssm_tile_sched: engine responder with fixed latency, scripted
// writeback backpressure, and hand-computed cycle numbers for each scenario.
module tb_ssm_tile_sched;
    localparam int IW = 4;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, err_timeout, tile_start, wb_valid;
    logic          tile_done;
    logic          eng_done = 1'b0;
    logic          stray_done = 1'b0;
    logic [IW-1:0] tile_h_idx, tile_p_idx;
    logic          wb_ready = 1'b1;
    logic [7:0]    tile_count;

    assign tile_done = eng_done | stray_done;

    ssm_tile_sched #(.H(24), .P(64), .H_TILE(12), .P_TILE(16), .IW(IW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .err_timeout(err_timeout), .tile_start(tile_start), .tile_done(tile_done),
        .tile_h_idx(tile_h_idx), .tile_p_idx(tile_p_idx), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .tile_count(tile_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Engine model: answers each launch L cycles later, except the scripted skip.
    int launches = 0;
    int skip_abs = -1;
    initial begin
        forever begin
            @(negedge clk);
            if (tile_start) begin
                launches++;
                if (launches - 1 != skip_abs) begin
                    repeat (L) @(posedge clk);
                    #1 eng_done = 1'b1;
                    @(posedge clk);
                    #1 eng_done = 1'b0;
                end
            end
        end
    end

    // Writeback side: scripted stalls, record accepted tiles, watch index stability.
    logic [IW-1:0] wb_h[$];
    logic [IW-1:0] wb_p[$];
    int bp_at = -1, bp_len = 0, stall = 0;
    int hold_seen = 0, hold_bad = 0;
    logic prev_stall = 1'b0;
    logic [IW-1:0] prev_h = '0, prev_p = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (wb_valid && prev_stall) begin
                hold_seen++;
                if (tile_h_idx !== prev_h || tile_p_idx !== prev_p) hold_bad++;
            end
            prev_stall = 1'b0;
            if (wb_valid) begin
                if (wb_h.size() == bp_at && stall < bp_len) begin
                    wb_ready   = 1'b0;
                    stall++;
                    prev_stall = 1'b1;
                    prev_h     = tile_h_idx;
                    prev_p     = tile_p_idx;
                end else begin
                    wb_ready = 1'b1;
                    stall    = 0;
                    wb_h.push_back(tile_h_idx);
                    wb_p.push_back(tile_p_idx);
                end
            end else begin
                wb_ready = 1'b1;
            end
        end
    end

    int done_cnt = 0, done_cyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int lim);
        int n = 0;
        while (done_cnt == prev && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", int'(done_cnt > prev), 1);
    endtask

    task automatic chk_seq(input string tag, input int base, input int n);
        chk({tag, "_ntiles"}, wb_h.size() - base, n);
        for (int i = 0; i < n && base + i < wb_h.size(); i++) begin
            chk({tag, "_h"}, int'(wb_h[base+i]), i / 4);
            chk({tag, "_p"}, int'(wb_p[base+i]), i % 4);
        end
    endtask

    initial begin
        int s, base, d0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state (rst still high)
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_timeout), 0);
        chk("rst_tstart", int'(tile_start), 0);
        chk("rst_wbv", int'(wb_valid), 0);
        chk("rst_idx", int'({tile_h_idx, tile_p_idx}), 0);
        chk("rst_cnt", int'(tile_count), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Nominal run
        base = wb_h.size(); d0 = done_cnt;
        pulse_start(s);
        @(negedge clk);
        chk("nom_launch", int'(tile_start), 1);
        wait_done(d0, 300);
        chk("nom_done_cyc", done_cyc - s, 97);
        chk("nom_cnt", int'(tile_count), 8);
        chk("nom_err", int'(err_timeout), 0);
        chk_seq("nom", base, 8);
        @(negedge clk);
        chk("nom_idle", int'(busy), 0);
        chk("nom_one_done", done_cnt - d0, 1);

        // Backpressure: three stalled cycles on tile 2
        goto(cyc + 3);
        base = wb_h.size(); d0 = done_cnt;
        bp_at = base + 2; bp_len = 3;
        pulse_start(s);
        wait_done(d0, 300);
        bp_at = -1;
        chk("bp_done_cyc", done_cyc - s, 100);
        chk("bp_hold_seen", hold_seen, 3);
        chk("bp_hold_bad", hold_bad, 0);
        chk_seq("bp", base, 8);

        // Timeout: engine silent on tile 3, WAIT at s+38 -> FINISH at s+54
        goto(cyc + 3);
        d0 = done_cnt;
        skip_abs = launches + 3;
        pulse_start(s);
        wait_done(d0, 300);
        chk("to_done_cyc", done_cyc - s, 54);
        chk("to_err", int'(err_timeout), 1);
        chk("to_cnt", int'(tile_count), 3);

        // Restart clears the error; abort in WAIT of tile 5
        goto(cyc + 3);
        d0 = done_cnt;
        pulse_start(s);
        @(negedge clk);
        chk("re_err_clr", int'(err_timeout), 0);
        goto(s + 65);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("ab_busy", int'(busy), 0);
        chk("ab_cnt", int'(tile_count), 5);
        goto(cyc + 20);
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_err", int'(err_timeout), 0);

        // Stray start in WAIT and stray tile_done in WRITE are ignored
        base = wb_h.size(); d0 = done_cnt;
        pulse_start(s);
        @(negedge clk);
        chk("re_idx", int'({tile_h_idx, tile_p_idx}), 0);
        goto(s + 5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        goto(s + 24);
        @(negedge clk);
        chk("stray_in_write", int'(wb_valid), 1);
        stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        wait_done(d0, 300);
        chk("stray_done_cyc", done_cyc - s, 97);
        chk_seq("stray", base, 8);

        // Reset during WRITE of tile 4 (WRITE at s+60)
        goto(cyc + 3);
        d0 = done_cnt;
        pulse_start(s);
        goto(s + 60);
        @(negedge clk);
        chk("rw_in_write", int'(wb_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rw_busy", int'(busy), 0);
        chk("rw_wbv", int'(wb_valid), 0);
        chk("rw_idx", int'({tile_h_idx, tile_p_idx}), 0);
        chk("rw_cnt", int'(tile_count), 0);
        chk("rw_no_done", done_cnt - d0, 0);

        // start together with abort in IDLE does nothing
        goto(cyc + 15);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        chk("sa_busy", int'(busy), 0);
        chk("sa_tstart", int'(tile_start), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule
